// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three write-back requesters (ALU, branch, LSBuf)
// each own one holding slot; one occupied slot per cycle is selected in
// round-robin order and broadcast through registered CDB outputs.
module cdb_arbiter #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              br_valid,
  input  logic [TAG_W-1:0]  br_tag,
  input  logic [DATA_W-1:0] br_data,
  output logic              br_ready,
  input  logic              lsb_valid,
  input  logic [TAG_W-1:0]  lsb_tag,
  input  logic [DATA_W-1:0] lsb_data,
  output logic              lsb_ready,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic [1:0]        cdb_src
);

  localparam int NREQ = 3;

  // Requester inputs gathered into arrays indexed 0=ALU, 1=BR, 2=LSB.
  logic [NREQ-1:0]   in_valid;
  logic [TAG_W-1:0]  in_tag  [NREQ];
  logic [DATA_W-1:0] in_data [NREQ];

  assign in_valid   = {lsb_valid, br_valid, alu_valid};
  assign in_tag[0]  = alu_tag;
  assign in_tag[1]  = br_tag;
  assign in_tag[2]  = lsb_tag;
  assign in_data[0] = alu_data;
  assign in_data[1] = br_data;
  assign in_data[2] = lsb_data;

  // Holding slots and round-robin pointer.
  logic [NREQ-1:0]   slot_v;
  logic [TAG_W-1:0]  slot_tag  [NREQ];
  logic [DATA_W-1:0] slot_data [NREQ];
  logic [1:0]        rr_ptr;

  // Arbitration results.
  logic              win_found;
  logic [1:0]        win_idx;
  logic [NREQ-1:0]   grant;
  logic [1:0]        next_rr;

  // Handshake qualifiers.
  logic [NREQ-1:0]   ready;
  logic [NREQ-1:0]   accept;
  logic [NREQ-1:0]   tag_nz;

  // Round-robin search starting at rr_ptr; first occupied slot wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && slot_v[idx]) begin
        win_found = 1'b1;
        win_idx   = 2'(idx);
      end
    end
    grant   = win_found ? (NREQ'(1) << win_idx) : '0;
    next_rr = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
  end

  // A slot can take a new result when empty or when it is being drained now.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      tag_nz[i] = (in_tag[i] != '0);
    end
    ready  = {NREQ{rst && !flush}} & (~slot_v | grant);
    accept = in_valid & ready;
  end

  assign alu_ready = ready[0];
  assign br_ready  = ready[1];
  assign lsb_ready = ready[2];

  // Control state and registered broadcast; reset beats flush beats normal.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      slot_v    <= '0;
      rr_ptr    <= 2'd0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= 2'd0;
    end else if (flush) begin
      slot_v    <= '0;
      rr_ptr    <= 2'd0;
      cdb_valid <= 1'b0;
    end else begin
      if (win_found) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= slot_tag[win_idx];
        cdb_data  <= slot_data[win_idx];
        cdb_src   <= win_idx;
        rr_ptr    <= next_rr;
      end else begin
        cdb_valid <= 1'b0;
      end
      // A same-cycle refill of the granted slot keeps it occupied; tagFree
      // results are accepted but never occupy a slot.
      slot_v <= (slot_v & ~grant) | (accept & tag_nz);
    end
  end

  // Slot payload capture on a transfer carrying a real tag.
  always_ff @(posedge clk) begin
    // NOTE: payload storage is deliberately not reset; slot_v qualifies it,
    // so stale contents are never observed.
    for (int i = 0; i < NREQ; i++) begin
      if (accept[i] && tag_nz[i]) begin
        slot_tag[i]  <= in_tag[i];
        slot_data[i] <= in_data[i];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        v [3];
  logic [3:0]  t [3];
  logic [31:0] d [3];

  logic        alu_ready, br_ready, lsb_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit          m_occ  [3];
  logic [3:0]  m_tag  [3];
  logic [31:0] m_data [3];
  int          m_rr;
  bit          m_cv;
  logic [3:0]  m_ct;
  logic [31:0] m_cd;
  int          m_cs;
  bit [2:0]    last_acc;

  always #5 clk = ~clk;

  cdb_arbiter #(.TAG_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst_i), .flush(flush_i),
    .alu_valid(v[0]), .alu_tag(t[0]), .alu_data(d[0]), .alu_ready(alu_ready),
    .br_valid(v[1]),  .br_tag(t[1]),  .br_data(d[1]),  .br_ready(br_ready),
    .lsb_valid(v[2]), .lsb_tag(t[2]), .lsb_data(d[2]), .lsb_ready(lsb_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_src(cdb_src)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Index of the slot that should be broadcast next, or -1 when all empty.
  function automatic int m_winner();
    for (int k = 0; k < 3; k++) begin
      if (m_occ[(m_rr + k) % 3]) return (m_rr + k) % 3;
    end
    return -1;
  endfunction

  // One clock: check readys before the edge, advance model, check CDB after.
  task automatic cyc();
    int w;
    bit [2:0] er;
    #1;
    w = m_winner();
    for (int i = 0; i < 3; i++)
      er[i] = rst_i && !flush_i && (!m_occ[i] || w == i);
    check("alu_ready", 32'(alu_ready), 32'(er[0]));
    check("br_ready",  32'(br_ready),  32'(er[1]));
    check("lsb_ready", 32'(lsb_ready), 32'(er[2]));
    for (int i = 0; i < 3; i++) last_acc[i] = v[i] && er[i];
    @(posedge clk);
    if (!rst_i) begin
      for (int i = 0; i < 3; i++) m_occ[i] = 1'b0;
      m_rr = 0; m_cv = 1'b0; m_ct = '0; m_cd = '0; m_cs = 0;
    end else if (flush_i) begin
      for (int i = 0; i < 3; i++) m_occ[i] = 1'b0;
      m_rr = 0; m_cv = 1'b0;
    end else begin
      if (w >= 0) begin
        m_cv = 1'b1; m_ct = m_tag[w]; m_cd = m_data[w]; m_cs = w;
        m_occ[w] = 1'b0;
        m_rr = (w + 1) % 3;
      end else begin
        m_cv = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (last_acc[i] && t[i] != 4'd0) begin
          m_occ[i] = 1'b1; m_tag[i] = t[i]; m_data[i] = d[i];
        end
      end
    end
    #1;
    check("cdb_valid", 32'(cdb_valid), 32'(m_cv));
    check("cdb_tag",   32'(cdb_tag),   32'(m_ct));
    check("cdb_data",  cdb_data,       m_cd);
    check("cdb_src",   32'(cdb_src),   32'(m_cs));
  endtask

  task automatic idle();
    for (int i = 0; i < 3; i++) v[i] = 1'b0;
  endtask

  task automatic offer(input int i, input int tg, input logic [31:0] dt);
    v[i] = 1'b1; t[i] = 4'(tg); d[i] = dt;
  endtask

  initial begin
    int prev_src;
    int tag_ctr;
    for (int i = 0; i < 3; i++) begin
      m_occ[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
      v[i] = 1'b0; t[i] = '0; d[i] = '0;
    end
    m_rr = 0; m_cv = 1'b0; m_ct = '0; m_cd = '0; m_cs = 0;

    // Reset held with all requesters offering.
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) offer(i, 7, 32'h1111_0000 + 32'(i));
    cyc(); cyc();
    check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    rst_i = 1'b1; idle();
    cyc();

    // Single ALU result: two-cycle latency, then idle.
    offer(0, 5, 32'hDEAD_BEEF);
    cyc();
    idle();
    cyc();
    check("t2_valid", 32'(cdb_valid), 32'd1);
    check("t2_tag",   32'(cdb_tag),   32'd5);
    check("t2_data",  cdb_data,       32'hDEAD_BEEF);
    check("t2_src",   32'(cdb_src),   32'd0);
    cyc();
    check("t2_gap", 32'(cdb_valid), 32'd0);

    // Flush to return rr_ptr to 0, then round-robin from 0.
    flush_i = 1'b1; cyc(); flush_i = 1'b0;
    for (int i = 0; i < 3; i++) offer(i, i + 1, 32'hA0 + 32'(i));
    cyc();
    idle();
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("t3a_tag", 32'(cdb_tag), 32'(k + 1));
      check("t3a_src", 32'(cdb_src), 32'(k));
    end

    // Advance rr_ptr to 2 via one branch broadcast, then expect 3,1,2.
    offer(1, 9, 32'h99); cyc(); idle(); cyc();
    for (int i = 0; i < 3; i++) offer(i, i + 1, 32'hB0 + 32'(i));
    cyc();
    idle();
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("t3b_tag", 32'(cdb_tag), 32'(((k + 2) % 3) + 1));
    end
    cyc();

    // Back-to-back ALU streaming, tags 1..8.
    for (int k = 1; k <= 8; k++) begin
      offer(0, k, 32'hC000 + 32'(k));
      cyc();
      check("t4_alu_ready", 32'(alu_ready), 32'd1);
      if (k >= 2) check("t4_stream_tag", 32'(cdb_tag), 32'(k - 1));
    end
    idle();
    cyc();
    check("t4_last_tag", 32'(cdb_tag), 32'd8);
    cyc();

    // Fairness: ALU and LSB continuously valid must alternate.
    tag_ctr = 1;
    offer(0, 1, 32'hD0); offer(2, 2, 32'hD1);
    prev_src = -1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      for (int i = 0; i < 3; i += 2) begin
        if (last_acc[i]) begin
          tag_ctr = (tag_ctr % 15) + 1;
          offer(i, tag_ctr, $urandom);
        end
      end
      if (k >= 2) check("t5_alternate", 32'(cdb_src), (prev_src == 0) ? 32'd2 : 32'd0);
      prev_src = int'(cdb_src);
    end
    idle();
    for (int k = 0; k < 3; k++) cyc();

    // Flush with full slots, then tagFree offer.
    for (int i = 0; i < 3; i++) offer(i, 7 + i, 32'hE0 + 32'(i));
    cyc();
    idle(); offer(0, 4, 32'h4444);
    flush_i = 1'b1;
    cyc();
    check("t6_flush_valid", 32'(cdb_valid), 32'd0);
    flush_i = 1'b0; idle();
    cyc();
    check("t6_empty_valid", 32'(cdb_valid), 32'd0);
    offer(1, 0, 32'h0BAD);
    cyc();
    check("t6_free_accept", 32'(last_acc[1]), 32'd1);
    idle();
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("t6_free_never", 32'(cdb_valid), 32'd0);
    end

    // Randomized traffic honouring hold-until-ready.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!v[i] && ($urandom % 4 != 0)) begin
          t[i] = ($urandom % 8 == 0) ? 4'd0 : 4'($urandom);
          d[i] = $urandom;
          v[i] = 1'b1;
        end
      end
      flush_i = ($urandom % 40 == 0);
      rst_i   = ($urandom % 300 != 0);
      cyc();
      for (int i = 0; i < 3; i++) if (last_acc[i]) v[i] = 1'b0;
    end
    rst_i = 1'b1; flush_i = 1'b0; idle();
    cyc(); cyc(); cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
